// File: rtl/jtag_tap_ir.sv
// jtag_tap_ir: IEEE 1149.1 TAP controller with instruction register, BYPASS,
// user DR channel select and an optional IDCODE register.
// Optional feature macro: JTAG_TAP_IR_IDCODE_EN (IDCODE register present and
// IDCODE is the default instruction; otherwise BYPASS is the default).
module jtag_tap_ir #(
  parameter int unsigned IR_WIDTH   = 8,
  parameter int unsigned NUM_USER   = 4,
  parameter int unsigned USER_BASE  = 32'h02,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001,
  parameter int unsigned IDCODE_OP  = 32'h01
) (
  input  logic                TCK,
  input  logic                TRST_N,
  input  logic                TMS,
  input  logic                TDI,
  input  logic [NUM_USER-1:0] USER_TDO,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                TLRESET,
  output logic                RTIDLE,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  output logic                SHIFT_IR,
  output logic                UPDATE_IR,
  output logic [NUM_USER-1:0] SEL,
  output logic [IR_WIDTH-1:0] IR_OUT
);

  // Elaboration-time parameter sanity; opcodes must fit the widest legal IR.
  if (IR_WIDTH < 2 || IR_WIDTH > 16 || NUM_USER < 1 || NUM_USER > 8 ||
      IDCODE_VAL[0] != 1'b1 || IDCODE_OP > 32'hFFFF ||
      USER_BASE + NUM_USER > 32'h1_0000) begin : g_param_check
    $error("jtag_tap_ir: parameter out of range");
  end

  typedef enum logic [3:0] {
    ST_TLR       = 4'h0,
    ST_RTI       = 4'h1,
    ST_SEL_DR    = 4'h2,
    ST_CAP_DR    = 4'h3,
    ST_SHIFT_DR  = 4'h4,
    ST_EXIT1_DR  = 4'h5,
    ST_PAUSE_DR  = 4'h6,
    ST_EXIT2_DR  = 4'h7,
    ST_UPD_DR    = 4'h8,
    ST_SEL_IR    = 4'h9,
    ST_CAP_IR    = 4'hA,
    ST_SHIFT_IR  = 4'hB,
    ST_EXIT1_IR  = 4'hC,
    ST_PAUSE_IR  = 4'hD,
    ST_EXIT2_IR  = 4'hE,
    ST_UPD_IR    = 4'hF
  } tap_state_e;

`ifdef JTAG_TAP_IR_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = IR_WIDTH'(IDCODE_OP);
`else
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = '1;
`endif

  // Decode: bit NUM_USER = IDCODE selected, low bits = one-hot user select.
  // An all-zero result means BYPASS.
  function automatic logic [NUM_USER:0] decode(input logic [IR_WIDTH-1:0] ir);
    logic [NUM_USER:0] d;
    d = '0;
    for (int unsigned k = 0; k < NUM_USER; k++) begin
      if (ir == IR_WIDTH'(USER_BASE + k)) d[k] = 1'b1;
    end
`ifdef JTAG_TAP_IR_IDCODE_EN
    if (ir == IR_WIDTH'(IDCODE_OP)) d = {1'b1, {NUM_USER{1'b0}}};
`endif
    if (ir == '1) d = '0;
    return d;
  endfunction

  tap_state_e            state, nextstate;
  logic [IR_WIDTH-1:0]   ir_shift;
  logic [NUM_USER:0]     dec_q;
  logic                  bypass_q;
  logic                  idcode_bit_c;
  logic                  dr_tdo_c;

  assign SEL = dec_q[NUM_USER-1:0];

  // TAP next-state logic, driven by TMS alone; unknown codes fall to reset.
  always_comb begin
    nextstate = ST_TLR;
    case (state)
      ST_TLR:      nextstate = TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      nextstate = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   nextstate = TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   nextstate = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: nextstate = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: nextstate = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: nextstate = TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: nextstate = TMS ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   nextstate = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   nextstate = TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   nextstate = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: nextstate = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: nextstate = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: nextstate = TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: nextstate = TMS ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   nextstate = TMS ? ST_SEL_DR   : ST_RTI;
      default:     nextstate = ST_TLR;
    endcase
  end

  // State register and one-hot flags registered from nextstate.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state      <= ST_TLR;
      TLRESET    <= 1'b1;
      RTIDLE     <= 1'b0;
      CAPTURE_DR <= 1'b0;
      SHIFT_DR   <= 1'b0;
      UPDATE_DR  <= 1'b0;
      SHIFT_IR   <= 1'b0;
      UPDATE_IR  <= 1'b0;
    end else begin
      state      <= nextstate;
      TLRESET    <= (nextstate == ST_TLR);
      RTIDLE     <= (nextstate == ST_RTI);
      CAPTURE_DR <= (nextstate == ST_CAP_DR);
      SHIFT_DR   <= (nextstate == ST_SHIFT_DR);
      UPDATE_DR  <= (nextstate == ST_UPD_DR);
      SHIFT_IR   <= (nextstate == ST_SHIFT_IR);
      UPDATE_IR  <= (nextstate == ST_UPD_IR);
    end
  end

  // IR shifter, instruction latch and registered decode (SEL only moves here).
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_shift <= '0;
      IR_OUT   <= IR_DEFAULT;
      dec_q    <= decode(IR_DEFAULT);
    end else begin
      if (state == ST_CAP_IR) begin
        ir_shift <= IR_WIDTH'(2'b01);
      end else if (state == ST_SHIFT_IR) begin
        ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
      end
      if (nextstate == ST_TLR) begin
        IR_OUT <= IR_DEFAULT;
        dec_q  <= decode(IR_DEFAULT);
      end else if (state == ST_UPD_IR) begin
        IR_OUT <= ir_shift;
        dec_q  <= decode(ir_shift);
      end
    end
  end

  // BYPASS register: captures 0, shifts TDI.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      bypass_q <= 1'b0;
    end else if (state == ST_CAP_DR) begin
      bypass_q <= 1'b0;
    end else if (state == ST_SHIFT_DR) begin
      bypass_q <= TDI;
    end
  end

`ifdef JTAG_TAP_IR_IDCODE_EN
  logic [31:0] idcode_q;

  // IDCODE register: active only while IDCODE is the current instruction.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      idcode_q <= '0;
    end else if (dec_q[NUM_USER]) begin
      if (state == ST_CAP_DR) begin
        idcode_q <= IDCODE_VAL;
      end else if (state == ST_SHIFT_DR) begin
        idcode_q <= {TDI, idcode_q[31:1]};
      end
    end
  end

  assign idcode_bit_c = idcode_q[0];
`else
  assign idcode_bit_c = 1'b0;
`endif

  // DR serial-out select from the registered decode.
  always_comb begin
    dr_tdo_c = bypass_q;
    if (|SEL)            dr_tdo_c = |(USER_TDO & SEL);
    if (dec_q[NUM_USER]) dr_tdo_c = idcode_bit_c;
  end

  // TDO and its enable re-registered on falling TCK; TDO parks at 0.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO_EN <= SHIFT_IR | SHIFT_DR;
      TDO    <= SHIFT_IR ? ir_shift[0] : (SHIFT_DR ? dr_tdo_c : 1'b0);
    end
  end

endmodule

// File: tb/tb_jtag_tap_ir.sv
// tb_jtag_tap_ir: directed + random TAP/IR/DR stimulus against a table-driven
// behavioural model of the JTAG TAP.
`timescale 1ns/1ps
module tb_jtag_tap_ir;

  localparam logic [31:0] IDV   = 32'h0000_0001;
  localparam logic [7:0]  IDOP  = 8'h01;
  localparam logic [7:0]  UBASE = 8'h02;
  localparam int          NU    = 4;
`ifdef JTAG_TAP_IR_IDCODE_EN
  localparam bit          HAS_ID = 1'b1;
  localparam logic [7:0]  IR_DEF = 8'h01;
`else
  localparam bit          HAS_ID = 1'b0;
  localparam logic [7:0]  IR_DEF = 8'hFF;
`endif

  // Standard TAP graph: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,6 PauseDR,
  // 7 Ex2DR,8 UpdDR,9 SelIR,10 CapIR,11 ShIR,12 Ex1IR,13 PauseIR,14 Ex2IR,15 UpdIR
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic       TCK = 1'b0, TRST_N = 1'b1, TMS = 1'b1, TDI = 1'b0;
  logic [3:0] USER_TDO = 4'h0;
  logic       TDO, TDO_EN;
  logic       TLRESET, RTIDLE, CAPTURE_DR, SHIFT_DR, UPDATE_DR, SHIFT_IR, UPDATE_IR;
  logic [3:0] SEL;
  logic [7:0] IR_OUT;

  int         n_assert = 0, n_fail = 0;
  int         ms = 0;
  logic [7:0] m_ir = IR_DEF, m_sh = 8'h00;
  logic       m_byp = 1'b0;
  logic [31:0] m_id = 32'h0;
  logic       obs_tdo = 1'b0;

  jtag_tap_ir #(
    .IR_WIDTH(8), .NUM_USER(4), .USER_BASE(32'h02),
    .IDCODE_VAL(32'h0000_0001), .IDCODE_OP(32'h01)
  ) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .USER_TDO(USER_TDO),
    .TDO(TDO), .TDO_EN(TDO_EN), .TLRESET(TLRESET), .RTIDLE(RTIDLE),
    .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR),
    .SHIFT_IR(SHIFT_IR), .UPDATE_IR(UPDATE_IR), .SEL(SEL), .IR_OUT(IR_OUT)
  );

  initial forever #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_flags(input int s);
    return {s == 0, s == 1, s == 3, s == 4, s == 8, s == 11, s == 15};
  endfunction

  function automatic logic [3:0] exp_sel(input logic [7:0] ir);
    logic [3:0] r;
    r = 4'h0;
    if (ir == 8'hFF || (HAS_ID && ir == IDOP)) return 4'h0;
    for (int k = 0; k < NU; k++) if (ir == UBASE + 8'(k)) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_dr_bit();
    logic [3:0] s;
    s = exp_sel(m_ir);
    if (s != 4'h0) return |(s & USER_TDO);
    if (HAS_ID && m_ir == IDOP) return m_id[0];
    return m_byp;
  endfunction

  function automatic logic [6:0] obs_flags();
    return {TLRESET, RTIDLE, CAPTURE_DR, SHIFT_DR, UPDATE_DR, SHIFT_IR, UPDATE_IR};
  endfunction

  // One TCK cycle: drive in low phase, model the rising edge, check, then
  // model and check the falling-edge TDO.
  task automatic tick(input logic tms, input logic tdi);
    int   ns;
    logic e_tdo;
    TMS = tms; TDI = tdi; USER_TDO = 4'($urandom);
    @(posedge TCK);
    ns = tms ? nx1[ms] : nx0[ms];
    case (ms)
      10: m_sh = 8'h01;
      11: m_sh = {tdi, m_sh[7:1]};
      3:  begin m_byp = 1'b0; m_id = IDV; end
      4:  begin m_byp = tdi; m_id = {tdi, m_id[31:1]}; end
      default: ;
    endcase
    if (ns == 0) m_ir = IR_DEF;
    else if (ms == 15) m_ir = m_sh;
    ms = ns;
    #1;
    chk("flags", 64'(obs_flags()), 64'(exp_flags(ms)));
    chk("ir_out", 64'(IR_OUT), 64'(m_ir));
    chk("sel", 64'(SEL), 64'(exp_sel(m_ir)));
    @(negedge TCK);
    e_tdo = (ms == 11) ? m_sh[0] : ((ms == 4) ? exp_dr_bit() : 1'b0);
    #1;
    chk("tdo", 64'(TDO), 64'(e_tdo));
    chk("tdo_en", 64'(TDO_EN), 64'(ms == 11 || ms == 4));
    obs_tdo = TDO;
  endtask

  // Asynchronous reset pulse; released in the next low phase.
  task automatic reset_pulse();
    TRST_N = 1'b0;
    #1;
    ms = 0; m_ir = IR_DEF; m_sh = 8'h00; m_byp = 1'b0; m_id = 32'h0;
    chk("rst_flags", 64'(obs_flags()), 64'(7'b1000000));
    chk("rst_tdo", 64'(TDO), 64'(1'b0));
    chk("rst_tdo_en", 64'(TDO_EN), 64'(1'b0));
    chk("rst_ir_out", 64'(IR_OUT), 64'(IR_DEF));
    chk("rst_sel", 64'(SEL), 64'(4'h0));
    @(negedge TCK);
    #1 TRST_N = 1'b1;
  endtask

  // IR scan from Run-Test/Idle back to Run-Test/Idle, LSB first.
  task automatic ir_scan(input logic [7:0] din, output logic [7:0] dout);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    dout[0] = obs_tdo;
    for (int i = 0; i < 8; i++) begin
      tick(i == 7, din[i]);
      if (i < 7) dout[i+1] = obs_tdo;
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
  endtask

  // DR scan of n bits (1..40) from Run-Test/Idle back to Run-Test/Idle.
  task automatic dr_scan(input int n, input logic [39:0] din, output logic [39:0] dout);
    dout = '0;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    dout[0] = obs_tdo;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      if (i < n - 1) dout[i+1] = obs_tdo;
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0]  irq;
    logic [39:0] dq, dd;
    logic [7:0]  op;
    int          n;

    reset_pulse();
    tick(1'b0, 1'b0);
    chk("idle_after_reset", 64'(RTIDLE), 64'(1'b1));
    chk("default_ir", 64'(IR_OUT), 64'(IR_DEF));

`ifdef JTAG_TAP_IR_IDCODE_EN
    dr_scan(32, 40'h0, dq);
    chk("idcode_stream", 64'(dq[31:0]), 64'(IDV));
`else
    dd = 40'($urandom);
    dr_scan(32, dd, dq);
    chk("bypass_default_stream", 64'(dq[31:0]), 64'({dd[30:0], 1'b0}));
`endif

    ir_scan(8'h03, irq);
    chk("ir_capture", 64'(irq), 64'(8'b0000_0001));
    chk("user2_sel", 64'(SEL), 64'(4'b0010));
    chk("user2_ir", 64'(IR_OUT), 64'(8'h03));

    ir_scan(8'hFF, irq);
    dr_scan(5, 40'b0_1011, dq);
    chk("bypass_delay", 64'(dq[4:0]), 64'(5'b1011_0));

    ir_scan(UBASE, irq);
    chk("user1_sel", 64'(SEL), 64'(4'b0001));
    dr_scan(12, 40'($urandom), dq);

    // Reach Pause_IR with a user instruction active, then five TMS=1 clocks.
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    chk("in_pause_ir", 64'(ms), 64'(13));
    repeat (5) tick(1'b1, 1'b0);
    chk("tlr_from_pause", 64'(TLRESET), 64'(1'b1));
    chk("tlr_sel", 64'(SEL), 64'(4'h0));
    chk("tlr_ir", 64'(IR_OUT), 64'(IR_DEF));
    tick(1'b0, 1'b0);

    // Random instruction / data scans.
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0:       op = 8'hFF;
        1:       op = IDOP;
        2:       op = UBASE + 8'($urandom_range(0, 3));
        default: op = 8'($urandom);
      endcase
      ir_scan(op, irq);
      chk("rand_ir_capture", 64'(irq), 64'(8'h01));
      chk("rand_ir_out", 64'(IR_OUT), 64'(op));
      n = $urandom_range(1, 40);
      dr_scan(n, {$urandom, $urandom}, dq);
    end

    // Random TMS walks, each terminated by five TMS=1 clocks.
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(1, 25)) tick($urandom_range(0, 3) == 0, 1'($urandom));
      repeat (5) tick(1'b1, 1'($urandom));
      chk("five_ones_tlr", 64'(TLRESET), 64'(1'b1));
    end

    // Fully random walk.
    repeat (400) tick($urandom_range(0, 2) == 0, 1'($urandom));

    // Reset asserted in the high phase of a Shift_IR cycle with USER3 active.
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    ir_scan(UBASE + 8'd2, irq);
    chk("user3_sel", 64'(SEL), 64'(4'b0100));
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1);
    @(posedge TCK);
    #2;
    reset_pulse();
    tick(1'b0, 1'b0);
    chk("post_midscan_ir", 64'(IR_OUT), 64'(IR_DEF));
    chk("post_midscan_idle", 64'(RTIDLE), 64'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
